// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package instruction_fetch_pkg;

    localparam int unsigned XLEN         = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0100;
    localparam logic [31:0] INSN_BYTES   = 32'd4;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] address;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    // Instruction addresses are word aligned: the two low-order bits are forced to zero.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Synchronous instruction buffer: registered storage, combinational head read, flush clears it.
module instruction_fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_c_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             full_q,   full_d;
    logic             empty_q,  empty_d;
    logic             do_push;
    logic             do_pop;
    logic             wr_en;

    // A pop frees the slot a same-cycle push may need, so push into a full buffer is legal with pop.
    assign do_pop  = pop_i && !empty_q;
    assign do_push = push_i && (!full_q || do_pop);
    assign wr_en   = do_push && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_c_o = mem_q[rd_ptr_q];
    assign full_o   = full_q;
    assign empty_o  = empty_q;
    assign count_o  = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues sequential word reads under a credit limit and
// buffers in-order responses for the core; a redirect flushes and drops stale responses.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDRESS = RESET_VECTOR,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_address,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_address,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,
    output logic            instruction_valid,
    input  logic            instruction_ready,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] instruction_address
);

    localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SW       = CW + 1;
    localparam logic [31:0] RESET_PC = word_align(RESET_ADDRESS);

    logic [31:0]   pc_q,          pc_d;
    logic [31:0]   resp_pc_q,     resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q,     discard_d;

    logic          credit_ok;
    logic          req_fire;
    logic          resp_drop;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  push_entry;
    fetch_entry_t  fifo_head;

    // Every issued request already owns a buffer slot, so responses can never be refused.
    assign credit_ok       = (SW'(outstanding_q) + SW'(fifo_count)) < SW'(FIFO_DEPTH);
    assign mem_req_valid   = rst && credit_ok && !redirect_valid;
    assign mem_req_address = pc_q;
    assign req_fire        = mem_req_valid && mem_req_ready;

    assign resp_drop = mem_resp_valid && (discard_q != '0);
    assign fifo_push = mem_resp_valid && !resp_drop && !redirect_valid;

    assign push_entry.instruction = mem_resp_data;
    assign push_entry.address     = resp_pc_q;

    assign instruction_valid   = !fifo_empty;
    assign fifo_pop            = instruction_valid && instruction_ready;
    assign instruction         = fifo_head.instruction;
    assign instruction_address = fifo_head.address;

    // Redirect wins over everything; responses still due (including one arriving now) become discards.
    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (redirect_valid) begin
            pc_d          = word_align(redirect_address);
            resp_pc_d     = word_align(redirect_address);
            outstanding_d = outstanding_q - CW'(mem_resp_valid);
            discard_d     = outstanding_q - CW'(mem_resp_valid);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + INSN_BYTES;
            end
            if (fifo_push) begin
                resp_pc_d = resp_pc_q + INSN_BYTES;
            end
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(mem_resp_valid);
            if (resp_drop) begin
                discard_d = discard_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    instruction_fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .head_c_o    (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        (fifo_push && fifo_full) |-> fifo_pop);
    a_resp_expected: assert property (@(posedge clk) disable iff (!rst)
        mem_resp_valid |-> (outstanding_q != '0));
    a_discard_bound: assert property (@(posedge clk) disable iff (!rst)
        discard_q <= outstanding_q);
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a 1-cycle memory model answers requests,
// a monitor checks request addresses and consumed instructions against queued expectations.
module tb_instruction_fetch;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] addr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_address;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_address;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        instruction_valid;
    logic        instruction_ready;
    logic [31:0] instruction;
    logic [31:0] instruction_address;

    logic        mem_stall;
    int          vectors;
    int          errors;
    int          req_fires;
    logic [31:0] pend[$];
    logic [31:0] exp_req[$];
    exp_t        exp_instr[$];

    instruction_fetch dut (
        .clk                 (clk),
        .rst                 (rst),
        .redirect_valid      (redirect_valid),
        .redirect_address    (redirect_address),
        .mem_req_valid       (mem_req_valid),
        .mem_req_ready       (mem_req_ready),
        .mem_req_address     (mem_req_address),
        .mem_resp_valid      (mem_resp_valid),
        .mem_resp_data       (mem_resp_data),
        .instruction_valid   (instruction_valid),
        .instruction_ready   (instruction_ready),
        .instruction         (instruction),
        .instruction_address (instruction_address)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic sync(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_req(input logic [31:0] a);
        exp_req.push_back(a);
    endtask

    task automatic push_instr(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.insn = d;
        exp_instr.push_back(e);
    endtask

    // Memory model (responds one cycle after acceptance unless stalled) plus output monitor.
    initial begin : mem_and_monitor
        logic [31:0] a;
        exp_t        e;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                pend.delete();
                mem_resp_valid = 1'b0;
            end else if (!mem_stall && pend.size() != 0) begin
                a = pend.pop_front();
                mem_resp_valid = 1'b1;
                mem_resp_data  = 32'h3821_0000 ^ a;
            end else begin
                mem_resp_valid = 1'b0;
            end
            @(negedge clk);
            if (rst && mem_req_valid && mem_req_ready) begin
                pend.push_back(mem_req_address);
                req_fires++;
                if (exp_req.size() != 0) begin
                    a = exp_req.pop_front();
                    vectors++;
                    if (mem_req_address !== a) begin
                        errors++;
                        $display("FAIL req_addr: got %h expected %h", mem_req_address, a);
                    end
                end
            end
            if (rst && instruction_valid && instruction_ready && !redirect_valid) begin
                vectors++;
                if (exp_instr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pop: got addr %h insn %h expected none",
                             instruction_address, instruction);
                end else begin
                    e = exp_instr.pop_front();
                    if (instruction_address !== e.addr || instruction !== e.insn) begin
                        errors++;
                        $display("FAIL pop: got addr %h insn %h expected addr %h insn %h",
                                 instruction_address, instruction, e.addr, e.insn);
                    end
                end
            end
        end
    end

    initial begin
        vectors           = 0;
        errors            = 0;
        req_fires         = 0;
        rst               = 1'b0;
        redirect_valid    = 1'b0;
        redirect_address  = '0;
        mem_req_ready     = 1'b1;
        instruction_ready = 1'b0;
        mem_stall         = 1'b0;

        sync(3);
        @(negedge clk);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_insn_valid", 32'(instruction_valid), 32'd0);
        chk("rst_req_addr", mem_req_address, 32'h0000_0100);
        chk("rst_insn", instruction, 32'h0);
        chk("rst_insn_addr", instruction_address, 32'h0);

        // Fill to the credit limit with the core stalled.
        for (int i = 0; i < 4; i++) push_req(32'h100 + 32'(4 * i));
        sync(1);
        rst = 1'b1;
        sync(12);
        @(negedge clk);
        chk("fill_req_count", 32'(req_fires), 32'd4);
        chk("fill_stalled", 32'(mem_req_valid), 32'd0);
        chk("fill_head_valid", 32'(instruction_valid), 32'd1);
        chk("fill_head_addr", instruction_address, 32'h0000_0100);
        chk("fill_head_insn", instruction, 32'h3821_0100);

        // Streaming: eight pops back to back.
        for (int i = 0; i < 8; i++) push_req(32'h110 + 32'(4 * i));
        for (int i = 0; i < 8; i++) push_instr(32'h100 + 32'(4 * i), 32'h3821_0100 + 32'(4 * i));
        sync(1);
        instruction_ready = 1'b1;
        sync(8);
        instruction_ready = 1'b0;
        sync(10);
        @(negedge clk);
        chk("stream_head_addr", instruction_address, 32'h0000_0120);
        chk("stream_stalled", 32'(mem_req_valid), 32'd0);

        // Redirect to unaligned 0x2003 with three responses outstanding.
        push_instr(32'h120, 32'h3821_0120);
        push_instr(32'h124, 32'h3821_0124);
        push_instr(32'h128, 32'h3821_0128);
        push_req(32'h130); push_req(32'h134); push_req(32'h138);
        push_req(32'h2000); push_req(32'h2004); push_req(32'h2008); push_req(32'h200C);
        sync(1);
        mem_stall = 1'b1;
        instruction_ready = 1'b1;
        sync(3);
        instruction_ready = 1'b0;
        sync(4);
        @(negedge clk);
        chk("out3_credit_stall", 32'(mem_req_valid), 32'd0);
        chk("out3_head_addr", instruction_address, 32'h0000_012C);
        sync(1);
        redirect_valid   = 1'b1;
        redirect_address = 32'h0000_2003;
        @(negedge clk);
        chk("redir_no_req", 32'(mem_req_valid), 32'd0);
        sync(1);
        redirect_valid = 1'b0;
        mem_stall      = 1'b0;
        @(negedge clk);
        chk("redir_flushed", 32'(instruction_valid), 32'd0);
        chk("redir_req_addr", mem_req_address, 32'h0000_2000);
        chk("redir_req_valid", 32'(mem_req_valid), 32'd1);
        sync(12);
        @(negedge clk);
        chk("redir_head_addr", instruction_address, 32'h0000_2000);
        chk("redir_head_insn", instruction, 32'h3821_2000);

        // Redirect in the same cycle as a response and a pop.
        push_instr(32'h2000, 32'h3821_2000);
        push_instr(32'h2004, 32'h3821_2004);
        push_req(32'h2010); push_req(32'h3000); push_req(32'h3004);
        push_req(32'h3008); push_req(32'h300C);
        sync(1);
        instruction_ready = 1'b1;
        sync(2);
        redirect_valid   = 1'b1;
        redirect_address = 32'h0000_3000;
        @(negedge clk);
        chk("collide_resp_present", 32'(mem_resp_valid), 32'd1);
        sync(1);
        redirect_valid    = 1'b0;
        instruction_ready = 1'b0;
        @(negedge clk);
        chk("collide_empty", 32'(instruction_valid), 32'd0);
        chk("collide_req_addr", mem_req_address, 32'h0000_3000);
        chk("collide_req_valid", 32'(mem_req_valid), 32'd1);
        sync(12);
        @(negedge clk);
        chk("collide_head_addr", instruction_address, 32'h0000_3000);
        chk("collide_head_insn", instruction, 32'h3821_3000);

        // PC wrap at the top of the address space.
        push_req(32'hFFFF_FFF8); push_req(32'hFFFF_FFFC); push_req(32'h0000_0000);
        push_req(32'h0000_0004); push_req(32'h0000_0008); push_req(32'h0000_000C);
        push_req(32'h0000_0010); push_req(32'h0000_0014);
        push_instr(32'hFFFF_FFF8, 32'hC7DE_FFF8);
        push_instr(32'hFFFF_FFFC, 32'hC7DE_FFFC);
        push_instr(32'h0000_0000, 32'h3821_0000);
        push_instr(32'h0000_0004, 32'h3821_0004);
        sync(1);
        redirect_valid   = 1'b1;
        redirect_address = 32'hFFFF_FFF8;
        sync(1);
        redirect_valid = 1'b0;
        sync(12);
        @(negedge clk);
        chk("wrap_head_addr", instruction_address, 32'hFFFF_FFF8);
        sync(1);
        instruction_ready = 1'b1;
        sync(4);
        instruction_ready = 1'b0;
        sync(12);
        @(negedge clk);
        chk("wrap_after_addr", instruction_address, 32'h0000_0008);
        chk("wrap_after_insn", instruction, 32'h3821_0008);

        // Reset mid-stream with a full buffer.
        sync(1);
        rst = 1'b0;
        sync(1);
        @(negedge clk);
        chk("midrst_insn_valid", 32'(instruction_valid), 32'd0);
        chk("midrst_req_addr", mem_req_address, 32'h0000_0100);
        chk("midrst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("midrst_insn_addr", instruction_address, 32'h0);
        for (int i = 0; i < 4; i++) push_req(32'h100 + 32'(4 * i));
        sync(1);
        rst = 1'b1;
        sync(12);
        @(negedge clk);
        chk("restart_head_addr", instruction_address, 32'h0000_0100);
        chk("restart_stalled", 32'(mem_req_valid), 32'd0);

        chk("req_queue_drained", 32'(exp_req.size()), 32'd0);
        chk("instr_queue_drained", 32'(exp_instr.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
